// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Drives imem/dmem handshakes and datapath strobes, counts retired instructions.
module cpu_seq_ctrl #(
    parameter int PC_W = 16,
    parameter int IW   = 32
) (
    input  logic            clk,
    input  logic            sys_rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_rdata,
    output logic [IW-1:0]   ir,
    output logic [PC_W-1:0] pc,
    input  logic            zero_flag,
    output logic            alu_en,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            gpr_we,
    output logic            retire,
    output logic            illegal_op,
    output logic            halted,
    output logic [15:0]     instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] pc_nx;
    logic [IW-1:0]   ir_nx;

    logic [4:0]      opcode;
    logic [PC_W-1:0] target;
    logic            is_alu;
    logic            is_mem;
    logic            is_store;
    logic            is_jmp;
    logic            is_jz;
    logic            is_halt;

    assign opcode   = ir[IW-1 -: 5];
    assign target   = ir[PC_W-1:0];
    assign is_alu   = ~opcode[4];
    assign is_store = (opcode == 5'h11);
    assign is_mem   = (opcode == 5'h10) | is_store;
    assign is_jmp   = (opcode == 5'h12);
    assign is_jz    = (opcode == 5'h13);
    assign is_halt  = (opcode == 5'h1F);

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
            if (retire)
                instr_count <= instr_count + 16'd1;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        ir_nx      = ir;
        imem_req   = 1'b0;
        alu_en     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        gpr_we     = 1'b0;
        retire     = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pc_nx    = '0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nx    = imem_rdata;
                    pc_nx    = pc + PC_W'(1);
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_alu: state_nx = S_EXEC;
                    is_mem: state_nx = S_MEM;
                    is_jmp: begin
                        pc_nx    = target;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                    is_jz: begin
                        if (zero_flag)
                            pc_nx = target;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                    is_halt: begin
                        retire   = 1'b1;
                        state_nx = S_HALT;
                    end
                    default: begin
                        // undefined opcodes retire as a NOP
                        illegal_op = 1'b1;
                        retire     = 1'b1;
                        state_nx   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alu_en   = 1'b1;
                state_nx = S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    retire   = is_store;
                    state_nx = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                gpr_we   = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_nx    = '0;
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: per-instruction retire expectations
// are queued at fetch time and matched when the sequencer retires.
module tb_cpu_seq_ctrl;

    logic        clk;
    logic        sys_rst_n;
    logic        start;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [15:0] pc;
    logic        zero_flag;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        gpr_we;
    logic        retire;
    logic        illegal_op;
    logic        halted;
    logic [15:0] instr_count;

    cpu_seq_ctrl #(.PC_W(16), .IW(32)) dut (
        .clk(clk),
        .sys_rst_n(sys_rst_n),
        .start(start),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .ir(ir),
        .pc(pc),
        .zero_flag(zero_flag),
        .alu_en(alu_en),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_ack(dmem_ack),
        .gpr_we(gpr_we),
        .retire(retire),
        .illegal_op(illegal_op),
        .halted(halted),
        .instr_count(instr_count)
    );

    typedef struct {
        logic        ill;
        logic        wb;
        logic [15:0] pc;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        pe;
    bit          pend;
    int          n_checks;
    int          n_errors;
    int          cyc;
    logic [15:0] mpc;
    logic [15:0] mcount;
    logic [31:0] last_ir;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, obs, exp, cyc);
        end
    endtask

    // retire monitor, sampled just after the falling edge
    always @(negedge clk) begin
        #1;
        if (!sys_rst_n) begin
            pend = 1'b0;
        end else begin
            check("mutex",
                  $countones({alu_en, gpr_we, dmem_req, imem_req}) <= 1, 1);
            check("ill_ret", illegal_op & ~retire, 0);
            if (pend) begin
                check("ret_pc", pc, pe.pc);
                check("ret_cnt", instr_count, pe.cnt);
                pend = 1'b0;
            end
            if (retire) begin
                check("sb_avail", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    pe = sb.pop_front();
                    check("ret_ill", illegal_op, pe.ill);
                    check("ret_wb", gpr_we, pe.wb);
                    check("ret_cyc", cyc, pe.cyc);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic run_instr(input logic [31:0] instr, input int id,
                             input int dd, input logic zf);
        logic [4:0] op;
        exp_t       e;
        int         n;
        bit         mem;
        bit         st;
        op  = instr[31:27];
        st  = (op == 5'h11);
        mem = (op == 5'h10) || st;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, mpc);
        zero_flag = zf;
        for (int i = 0; i < id; i++) begin
            imem_rdata = $urandom;
            @(negedge clk);
            check("fetch_hold", {imem_req, imem_addr}, {1'b1, mpc});
            check("ir_hold", ir, last_ir);
        end
        e.ill = !((op <= 5'h13) || (op == 5'h1F));
        e.wb  = (op <= 5'h10);
        e.cnt = mcount + 16'd1;
        e.pc  = mpc + 16'd1;
        if (op == 5'h12 || (op == 5'h13 && zf))
            e.pc = instr[15:0];
        if (op < 5'h10)       e.cyc = cyc + 3;
        else if (op == 5'h10) e.cyc = cyc + 3 + dd;
        else if (op == 5'h11) e.cyc = cyc + 2 + dd;
        else                  e.cyc = cyc + 1;
        sb.push_back(e);
        mpc    = e.pc;
        mcount = e.cnt;
        imem_ack   = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("ir_load", ir, instr);
        last_ir = instr;
        if (mem) begin
            n = 0;
            while (!dmem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("mem_req", dmem_req, 1);
            if (dd < 0)
                return;
            for (int i = 0; i < dd; i++) begin
                imem_ack   = 1'b1;
                imem_rdata = $urandom;
                check("mem_hold", {dmem_req, dmem_we}, {1'b1, st});
                @(negedge clk);
            end
            imem_ack = 1'b0;
            check("mem_hold", {dmem_req, dmem_we}, {1'b1, st});
            dmem_ack = 1'b1;
            @(negedge clk);
            dmem_ack = 1'b0;
            check("mem_drop", dmem_req, 0);
            check("ir_keep", ir, instr);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_req", imem_req, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [4:0]  rop;
        logic [26:0] rlo;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        pend       = 1'b0;
        mpc        = '0;
        mcount     = '0;
        last_ir    = '0;
        sys_rst_n  = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        zero_flag  = 1'b0;
        dmem_ack   = 1'b0;
        #12;
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_cnt", instr_count, 0);
        check("rst_out", {imem_req, alu_en, dmem_req, gpr_we, retire,
                          illegal_op, halted}, 0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_hold", {imem_req, halted}, 0);
        end

        pulse_start();
        run_instr(32'h0000_0000, 0, 0, 1'b0);
        run_instr(32'h9000_0040, 0, 0, 1'b0);
        run_instr(32'h9800_0020, 0, 0, 1'b0);
        run_instr(32'h9800_0020, 0, 0, 1'b1);
        run_instr(32'h8000_0000, 0, 3, 1'b0);
        run_instr(32'h8800_0000, 1, 2, 1'b0);
        start = 1'b1;
        run_instr(32'h2800_1234, 5, 0, 1'b0);
        start = 1'b0;
        run_instr(32'hA800_0000, 0, 0, 1'b0);
        run_instr(32'h9000_FFFF, 0, 0, 1'b0);
        run_instr(32'h0000_0000, 2, 0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            rop = 5'($urandom_range(0, 30));
            rlo = 27'($urandom);
            run_instr({rop, rlo}, $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        run_instr(32'hF800_0000, 0, 0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("halt_hold", {halted, imem_req}, 2'b10);
        end
        pulse_start();
        mpc = '0;
        run_instr(32'h0800_0000, 0, 0, 1'b0);

        run_instr(32'h8000_0000, 0, -1, 1'b0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_dreq", dmem_req, 0);
        check("arst_pc", pc, 0);
        check("arst_cnt", instr_count, 0);
        check("arst_out", {imem_req, retire, gpr_we, halted}, 0);
        sb.delete();
        mpc     = '0;
        mcount  = '0;
        last_ir = '0;
        @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_after", imem_req, 0);
        end
        pulse_start();
        run_instr(32'h0000_0000, 0, 0, 1'b0);
        repeat (6) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter and imem address width.
REQ-002 SHALL have parameter IW, default 32, instruction width; opcode = ir[IW-1:IW-5], jump target = ir[PC_W-1:0].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin or restart execution from address 0.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  PC_W  fetch address, equal to pc.
REQ-008 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-009 imem_rdata  input  IW  fetched instruction.
REQ-010 ir  output  IW  current instruction register.
REQ-011 pc  output  PC_W  program counter.
REQ-012 zero_flag  input  1  datapath zero flag, sampled in DECODE.
REQ-013 alu_en  output  1  one-cycle datapath execute strobe.
REQ-014 dmem_req / dmem_we  output  1 / 1  data access request / write qualifier.
REQ-015 dmem_ack  input  1  data access complete.
REQ-016 gpr_we  output  1  one-cycle register-file write strobe.
REQ-017 retire  output  1  one-cycle pulse per completed instruction.
REQ-018 illegal_op  output  1  one-cycle pulse on undefined opcode.
REQ-019 halted  output  1  high while in HALT.
REQ-020 instr_count  output  16  retired-instruction counter, wraps at 16'hFFFF.

Function
REQ-021 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-022 IDLE: all strobes low; start=1 -> pc<=0, go FETCH.
REQ-023 FETCH: imem_req=1 held with stable imem_addr until imem_ack; on ack ir<=imem_rdata, pc<=pc+1 (wraps FFFF->0), go DECODE.
REQ-024 DECODE (exactly one cycle), by opcode: 5'h00-5'h0F ALU -> EXEC; 5'h10 LOAD, 5'h11 STORE -> MEM; 5'h12 JMP -> pc<=target, retire, FETCH; 5'h13 JZ -> pc<=target only if zero_flag=1, retire, FETCH; 5'h1F HALT -> retire, HALT; other -> illegal_op=1, retire, FETCH (NOP).
REQ-025 EXEC: alu_en=1 for one cycle -> WB.
REQ-026 MEM: dmem_req=1 held until dmem_ack; dmem_we=1 throughout only for STORE; on ack LOAD -> WB, STORE -> retire, FETCH.
REQ-027 WB: gpr_we=1 for one cycle, retire -> FETCH.
REQ-028 retire SHALL increment instr_count by 1 in the same cycle edge; 16'hFFFF+1 -> 0.
REQ-029 Minimum latency with ack in the request cycle: ALU/LOAD 4 cycles, STORE 3, JMP/JZ/illegal 2 per instruction.
REQ-030 HALT: halted=1, no requests; start=1 -> pc<=0, instr_count held, FETCH.
REQ-031 start SHALL be ignored in all states other than IDLE and HALT.
REQ-032 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-033 alu_en, gpr_we, dmem_req, imem_req SHALL be mutually exclusive in any cycle.

Reset
REQ-034 sys_rst_n=0 SHALL immediately force IDLE, pc=0, ir=0, instr_count=0, all outputs 0, including mid-transaction (pending requests dropped, no retire).
REQ-035 After deassertion, block SHALL remain in IDLE until start.

Verification
REQ-036 Reset, start, imem returns ALU op 0x00000000 with ack same cycle -> imem_req@1, alu_en@3, gpr_we@4, retire@4, pc=1, instr_count=1.
REQ-037 JMP 0x9000_0040 at pc=0 -> next imem_addr=0x0040; JZ 0x9800_0020 with zero_flag=0 -> next imem_addr=pc+1, with zero_flag=1 -> 0x0020.
REQ-038 LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then gpr_we one cycle; STORE -> dmem_we=1, no gpr_we.
REQ-039 imem_ack delayed 5 cycles -> imem_req and imem_addr stable for 6 cycles, ir updates only on ack.
REQ-040 Opcode 5'h15 -> illegal_op pulse, retire, pc advances; HALT 0xF800_0000 -> halted=1 persists, start -> imem_addr=0, instr_count unchanged.
REQ-041 sys_rst_n low during MEM wait -> dmem_req drops same cycle (async), pc=0, instr_count=0, state IDLE.
